// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: opcodes the stage
// classifies on, and the bit positions inside the {N,Z,C,V} status word.
package alu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_CMP = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_DIV = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_MOD = 5'b01110;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  // True for the two opcodes that can raise a divide fault.
  function automatic logic is_div_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Small synchronous FIFO with a registered head output. The head register
// is reset to zero and keeps its last value once the FIFO drains, so the
// consumer never sees stale or undefined slots on dout.
module alu_wb_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // Storage array: written on push only.
  // NOTE: the data array carries no reset; occupancy is tracked by count and
  // the pointers, so unreset slots are never observed and stay plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and head register; pointers wrap naturally at DEPTH.
  // NOTE: every sequential update uses <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);

      // Head update: next older entry after a pop, or the incoming word when
      // it becomes the new head; otherwise hold (including when drained).
      if (do_pop && count > CNT_W'(1)) dout <= mem[rd_ptr_nxt];
      else if (do_push && (empty || (do_pop && count == CNT_W'(1)))) dout <= din;
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: classifies accepted results, queues
// register-file writebacks, holds the {N,Z,C,V} status register, tracks a
// sticky divide fault and counts retired operations.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_set_flags,
  input  logic [WIDTH-1:0]      in_r,
  input  logic                  in_negative,
  input  logic                  in_zero,
  input  logic                  in_cout,
  input  logic                  in_overflow,
  input  logic                  in_div_invalid,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic [3:0]            status,
  output logic                  div_fault,
  output logic                  div_fault_pulse,
  input  logic                  fault_clear,
  output logic [15:0]           retire_count
);

  localparam int DW    = REG_ADDR_W + WIDTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             accept;
  logic             is_cmp;
  logic             fault;
  logic             push;
  logic             pop;
  logic             flag_upd;
  logic [DW-1:0]    fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready is a function of registered occupancy only; wb_ready never reaches it.
  assign in_ready = (fifo_count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign is_cmp   = (in_opcode == OP_CMP);
  assign fault    = is_div_op(in_opcode) && in_div_invalid;
  assign push     = accept && !is_cmp && !fault;
  assign flag_upd = accept && in_set_flags && !fault;

  assign wb_valid = !fifo_empty;
  assign pop      = wb_valid && wb_ready;
  assign {wb_addr, wb_data} = fifo_dout;

  alu_wb_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_dest, in_r}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status register, sticky fault with set-over-clear priority, retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      status          <= '0;
      div_fault       <= 1'b0;
      div_fault_pulse <= 1'b0;
      retire_count    <= '0;
    end else begin
      if (flag_upd) begin
        status[ST_N] <= in_negative;
        status[ST_Z] <= in_zero;
        status[ST_C] <= in_cout;
        status[ST_V] <= in_overflow;
      end
      div_fault_pulse <= accept && fault;
      if (accept && fault)  div_fault <= 1'b1;
      else if (fault_clear) div_fault <= 1'b0;
      if (accept) retire_count <= retire_count + 16'd1;
    end
  end

  // Consistency guard between the FIFO's full flag and its occupancy.
  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_full == (fifo_count == CNT_W'(DEPTH)));
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the same point.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [2:0]  in_dest;
  logic        in_set_flags;
  logic [15:0] in_r;
  logic        in_negative, in_zero, in_cout, in_overflow;
  logic        in_div_invalid;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  status;
  logic        div_fault;
  logic        div_fault_pulse;
  logic        fault_clear;
  logic [15:0] retire_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.WIDTH(16), .REG_ADDR_W(3), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_opcode       (in_opcode),
    .in_dest         (in_dest),
    .in_set_flags    (in_set_flags),
    .in_r            (in_r),
    .in_negative     (in_negative),
    .in_zero         (in_zero),
    .in_cout         (in_cout),
    .in_overflow     (in_overflow),
    .in_div_invalid  (in_div_invalid),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .status          (status),
    .div_fault       (div_fault),
    .div_fault_pulse (div_fault_pulse),
    .fault_clear     (fault_clear),
    .retire_count    (retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op; flags given as {N,Z,C,V}.
  task automatic drive(input logic [4:0] op, input logic [2:0] dest, input logic [15:0] r,
                       input logic sf, input logic [3:0] nzcv, input logic dinv);
    in_valid       = 1'b1;
    in_opcode      = op;
    in_dest        = dest;
    in_r           = r;
    in_set_flags   = sf;
    {in_negative, in_zero, in_cout, in_overflow} = nzcv;
    in_div_invalid = dinv;
  endtask

  initial begin
    rst = 1'b1; wb_ready = 1'b0; fault_clear = 1'b0;
    drive(5'd0, 3'd0, 16'h0, 1'b0, 4'b0000, 1'b0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_status", status, 0);
    chk("rst_div_fault", div_fault, 0);
    chk("rst_pulse", div_fault_pulse, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Add writeback, no bypass even with wb_ready=1
    wb_ready = 1'b1;
    drive(5'b00001, 3'd3, 16'h1234, 1'b1, 4'b0010, 1'b0);
    step();
    in_valid = 1'b0;
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_addr", wb_addr, 3);
    chk("add_wb_data", wb_data, 16'h1234);
    chk("add_status", status, 4'b0010);
    chk("add_retire", retire_count, 1);
    step();
    chk("add_drained", wb_valid, 0);
    chk("empty_holds_data", wb_data, 16'h1234);
    chk("empty_holds_addr", wb_addr, 3);

    // Backpressure: A, B accepted, C stalled
    wb_ready = 1'b0;
    drive(5'b00010, 3'd1, 16'hAAAA, 1'b0, 4'b1111, 1'b0);
    chk("bp_ready_a", in_ready, 1);
    step();
    drive(5'b00010, 3'd2, 16'hBBBB, 1'b0, 4'b1111, 1'b0);
    chk("bp_ready_b", in_ready, 1);
    step();
    drive(5'b00010, 3'd4, 16'hCCCC, 1'b0, 4'b1111, 1'b0);
    chk("bp_ready_c_low", in_ready, 0);
    step();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_head", wb_data, 16'hAAAA);
    chk("bp_stall_retire", retire_count, 3);
    wb_ready = 1'b1;
    chk("bp_out_a", wb_data, 16'hAAAA);
    chk("bp_out_a_addr", wb_addr, 1);
    step();
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_out_b", wb_data, 16'hBBBB);
    chk("bp_out_b_addr", wb_addr, 2);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", wb_data, 16'hCCCC);
    chk("bp_out_c_valid", wb_valid, 1);
    chk("bp_retire", retire_count, 4);
    chk("bp_status_held", status, 4'b0010);
    step();
    chk("bp_drained", wb_valid, 0);

    // CMP: flags only
    drive(5'b00101, 3'd7, 16'h5555, 1'b1, 4'b0100, 1'b0);
    step();
    in_valid = 1'b0;
    chk("cmp_no_push", wb_valid, 0);
    chk("cmp_status", status, 4'b0100);
    chk("cmp_retire", retire_count, 5);

    // Divide fault: no push, no flag update
    drive(5'b01101, 3'd5, 16'hFFFF, 1'b1, 4'b1011, 1'b1);
    step();
    in_valid = 1'b0;
    chk("div_no_push", wb_valid, 0);
    chk("div_status_held", status, 4'b0100);
    chk("div_fault_set", div_fault, 1);
    chk("div_pulse_on", div_fault_pulse, 1);
    chk("div_retire", retire_count, 6);
    step();
    chk("div_pulse_off", div_fault_pulse, 0);
    chk("div_fault_sticky", div_fault, 1);

    // Fault clear alone, then clear colliding with a new MOD fault
    fault_clear = 1'b1;
    step();
    chk("clr_fault", div_fault, 0);
    chk("clr_pulse", div_fault_pulse, 0);
    drive(5'b01110, 3'd1, 16'h0000, 1'b0, 4'b0000, 1'b1);
    step();
    in_valid = 1'b0; fault_clear = 1'b0;
    chk("coll_fault", div_fault, 1);
    chk("coll_pulse", div_fault_pulse, 1);
    chk("coll_retire", retire_count, 7);

    // DIV without invalid flag is an ordinary writeback
    wb_ready = 1'b0;
    drive(5'b01101, 3'd5, 16'h0007, 1'b1, 4'b0001, 1'b0);
    step();
    chk("divok_push", wb_valid, 1);
    chk("divok_data", wb_data, 16'h0007);
    chk("divok_status", status, 4'b0001);

    // Fill to full, then reset with two queued entries
    drive(5'b00000, 3'd6, 16'h2222, 1'b0, 4'b0000, 1'b0);
    step();
    in_valid = 1'b0;
    chk("full_ready", in_ready, 0);
    chk("full_head_stable", wb_data, 16'h0007);
    chk("full_retire", retire_count, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_status", status, 0);
    chk("mrst_retire", retire_count, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_fault", div_fault, 0);
    wb_ready = 1'b1;
    step();
    chk("mrst_no_wb", wb_valid, 0);

    // Counter wrap: 65536 back-to-back CMP accepts
    drive(5'b00101, 3'd0, 16'h0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 65535; i++) step();
    chk("wrap_ffff", retire_count, 16'hFFFF);
    step();
    in_valid = 1'b0;
    chk("wrap_zero", retire_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
